// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-unit bundle: decode/execute/memory stage hazard inputs and the
// stall, flush and HI/LO busy outputs.
interface pipe_stall_ctrl_if;
  logic       IntExcReq;
  logic [4:0] D_RsAddr;
  logic [4:0] D_RtAddr;
  logic [1:0] D_TuseRs;
  logic [1:0] D_TuseRt;
  logic       D_IsMD;
  logic [4:0] E_WriteAddr;
  logic       E_RegWrite;
  logic [1:0] E_Tnew;
  logic [4:0] M_WriteAddr;
  logic       M_RegWrite;
  logic [1:0] M_Tnew;
  logic       E_MDStart;
  logic       E_MDOp;
  logic       Stall;
  logic       FlushDE;
  logic       MDBusy;
  logic [3:0] MDCount;

  // master: the pipeline that presents stage info and consumes stall/flush
  modport master (
    output IntExcReq, D_RsAddr, D_RtAddr, D_TuseRs, D_TuseRt, D_IsMD,
           E_WriteAddr, E_RegWrite, E_Tnew, M_WriteAddr, M_RegWrite, M_Tnew,
           E_MDStart, E_MDOp,
    input  Stall, FlushDE, MDBusy, MDCount
  );

  modport slave (
    input  IntExcReq, D_RsAddr, D_RtAddr, D_TuseRs, D_TuseRt, D_IsMD,
           E_WriteAddr, E_RegWrite, E_Tnew, M_WriteAddr, M_RegWrite, M_Tnew,
           E_MDStart, E_MDOp,
    output Stall, FlushDE, MDBusy, MDCount
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: Tuse/Tnew register hazards plus a
// HI/LO busy tracker that holds off MD instructions while mult/div runs.
//
//   state | meaning
//   ------+-----------------------------------------------------
//   IDLE  | HI/LO unit free, MDCount held at 0
//   BUSY  | mult/div in flight, MDCount counts remaining cycles
module pipe_stall_ctrl (
  input logic              clk,
  input logic              reset,
  pipe_stall_ctrl_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  state_t     state, state_nxt;
  logic [3:0] count, count_nxt;
  logic       rs_haz, rt_haz, md_haz;
  logic       md_busy;

  assign md_busy = (state == BUSY);

  // A producer only stalls D if its result arrives later than D needs it.
  assign rs_haz = (bus.D_RsAddr != 5'd0) && (bus.D_TuseRs != 2'd3) &&
                  ((bus.E_RegWrite && (bus.E_WriteAddr == bus.D_RsAddr) &&
                    (bus.E_Tnew > bus.D_TuseRs)) ||
                   (bus.M_RegWrite && (bus.M_WriteAddr == bus.D_RsAddr) &&
                    (bus.M_Tnew > bus.D_TuseRs)));

  assign rt_haz = (bus.D_RtAddr != 5'd0) && (bus.D_TuseRt != 2'd3) &&
                  ((bus.E_RegWrite && (bus.E_WriteAddr == bus.D_RtAddr) &&
                    (bus.E_Tnew > bus.D_TuseRt)) ||
                   (bus.M_RegWrite && (bus.M_WriteAddr == bus.D_RtAddr) &&
                    (bus.M_Tnew > bus.D_TuseRt)));

  assign md_haz = bus.D_IsMD && (md_busy || bus.E_MDStart);

  assign bus.Stall   = (rs_haz || rt_haz || md_haz) && !bus.IntExcReq;
  assign bus.FlushDE = bus.Stall || bus.IntExcReq;
  assign bus.MDBusy  = md_busy;
  assign bus.MDCount = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        count_nxt = 4'd0;
        // An exception in the start cycle squashes the mult/div itself.
        if (bus.E_MDStart && !bus.IntExcReq) begin
          state_nxt = BUSY;
          count_nxt = bus.E_MDOp ? DIV_CYCLES : MULT_CYCLES;
        end
      end
      BUSY: begin
        if (count <= 4'd1) begin
          state_nxt = IDLE;
          count_nxt = 4'd0;
        end else begin
          count_nxt = count - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed cycles push expected
// {Stall, FlushDE, MDBusy, MDCount}; a monitor pops and compares.
module tb_pipe_stall_ctrl;
  logic clk;
  logic reset;
  logic chk_now;
  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string      nm;
    logic [6:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Sample on the falling edge, or immediately on request for async checks.
  initial begin
    exp_t       e;
    logic [6:0] act;
    forever begin
      @(negedge clk or posedge chk_now);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {bus.Stall, bus.FlushDE, bus.MDBusy, bus.MDCount};
        n_cmp++;
        if (act !== e.exp) begin
          n_err++;
          $display("FAIL %s: got stall=%b flush=%b busy=%b cnt=%0d, required stall=%b flush=%b busy=%b cnt=%0d",
                   e.nm, act[6], act[5], act[4], act[3:0],
                   e.exp[6], e.exp[5], e.exp[4], e.exp[3:0]);
        end
      end
    end
  end

  task automatic push(input string nm, input logic s, input logic f,
                      input logic b, input logic [3:0] c);
    exp_t e;
    e.nm  = nm;
    e.exp = {s, f, b, c};
    q.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.IntExcReq   = 1'b0;
    bus.D_RsAddr    = 5'd0;
    bus.D_RtAddr    = 5'd0;
    bus.D_TuseRs    = 2'd3;
    bus.D_TuseRt    = 2'd3;
    bus.D_IsMD      = 1'b0;
    bus.E_WriteAddr = 5'd0;
    bus.E_RegWrite  = 1'b0;
    bus.E_Tnew      = 2'd0;
    bus.M_WriteAddr = 5'd0;
    bus.M_RegWrite  = 1'b0;
    bus.M_Tnew      = 2'd0;
    bus.E_MDStart   = 1'b0;
    bus.E_MDOp      = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    chk_now = 1'b0;
    reset   = 1'b1;
    clr();

    // Reset held: outputs are pure functions of the inputs
    next(); push("reset_idle", 0, 0, 0, 4'd0);
    next(); bus.IntExcReq = 1; push("reset_exc", 0, 1, 0, 4'd0);
    next(); clr(); bus.D_RsAddr = 8; bus.D_TuseRs = 0;
    bus.E_RegWrite = 1; bus.E_WriteAddr = 8; bus.E_Tnew = 2;
    push("reset_hazard", 1, 1, 0, 4'd0);
    next(); clr(); bus.E_MDStart = 1; push("reset_start", 0, 0, 0, 4'd0);
    next(); clr(); reset = 0; push("release", 0, 0, 0, 4'd0);

    // Load-use from E
    next(); bus.D_RsAddr = 8; bus.D_TuseRs = 0;
    bus.E_RegWrite = 1; bus.E_WriteAddr = 8; bus.E_Tnew = 2;
    push("load_use", 1, 1, 0, 4'd0);
    next(); bus.D_RsAddr = 0; push("load_use_r0", 0, 0, 0, 4'd0);
    next(); bus.D_RsAddr = 8; bus.E_Tnew = 0; push("e_tnew_eq", 0, 0, 0, 4'd0);
    next(); bus.E_Tnew = 2; bus.E_RegWrite = 0; push("e_nowrite", 0, 0, 0, 4'd0);
    next(); bus.E_RegWrite = 1; bus.IntExcReq = 1; push("hazard_exc", 0, 1, 0, 4'd0);

    // M-stage boundary on rt
    next(); clr(); bus.M_RegWrite = 1; bus.M_WriteAddr = 9; bus.M_Tnew = 1;
    bus.D_RtAddr = 9; bus.D_TuseRt = 0; push("m_rt_tuse0", 1, 1, 0, 4'd0);
    next(); bus.D_TuseRt = 1; push("m_rt_tuse1", 0, 0, 0, 4'd0);
    next(); bus.D_TuseRt = 3; push("m_rt_tuse3", 0, 0, 0, 4'd0);
    // rt from E, rs from M
    next(); clr(); bus.E_RegWrite = 1; bus.E_WriteAddr = 3; bus.E_Tnew = 1;
    bus.D_RtAddr = 3; bus.D_TuseRt = 0; push("e_rt", 1, 1, 0, 4'd0);
    next(); clr(); bus.M_RegWrite = 1; bus.M_WriteAddr = 4; bus.M_Tnew = 2;
    bus.D_RsAddr = 4; bus.D_TuseRs = 1; push("m_rs_tuse1", 1, 1, 0, 4'd0);
    next(); bus.D_TuseRs = 2; push("m_rs_tuse2", 0, 0, 0, 4'd0);

    // Divide: 10 busy cycles; exception and second start ignored mid-way
    next(); clr(); bus.E_MDStart = 1; bus.E_MDOp = 1; push("div_start", 0, 0, 0, 4'd0);
    for (int i = 10; i >= 1; i--) begin
      next(); clr(); bus.D_IsMD = 1;
      bus.IntExcReq = (i == 7);
      bus.E_MDStart = (i == 5);
      push($sformatf("div_cnt%0d", i), (i != 7), 1, 1, i[3:0]);
    end
    next(); clr(); bus.D_IsMD = 1; push("div_done", 0, 0, 0, 4'd0);

    // Start suppressed by exception
    next(); clr(); bus.E_MDStart = 1; bus.IntExcReq = 1; push("suppress", 0, 1, 0, 4'd0);
    next(); clr(); push("suppress_idle", 0, 0, 0, 4'd0);

    // Async reset mid-multiply at count 3
    next(); bus.E_MDStart = 1; push("mul_start", 0, 0, 0, 4'd0);
    for (int i = 5; i >= 3; i--) begin
      next(); clr(); push($sformatf("mul_cnt%0d", i), 0, 0, 1, i[3:0]);
    end
    @(negedge clk); #2;
    reset = 1; #1;
    push("async_reset", 0, 0, 0, 4'd0);
    chk_now = 1; #1 chk_now = 0;
    next(); push("reset_hold", 0, 0, 0, 4'd0);
    next(); reset = 0; push("reset_rel2", 0, 0, 0, 4'd0);
    next(); bus.E_MDStart = 1; push("mul2_start", 0, 0, 0, 4'd0);
    for (int i = 5; i >= 1; i--) begin
      next(); clr(); push($sformatf("mul2_cnt%0d", i), 0, 0, 1, i[3:0]);
    end
    next(); push("mul2_done", 0, 0, 0, 4'd0);

    // Start together with mf* in D
    next(); bus.E_MDStart = 1; bus.D_IsMD = 1; push("mf_start", 1, 1, 0, 4'd0);
    for (int i = 5; i >= 1; i--) begin
      next(); clr(); bus.D_IsMD = 1; push($sformatf("mf_cnt%0d", i), 1, 1, 1, i[3:0]);
    end
    next(); push("mf_done", 0, 0, 0, 4'd0);

    next(); clr();
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
